dma_copy_ctrl: RTL and testbench
================================

DMA_COPY_CTRL -- requirements
Module: dma_copy_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of one transferred word.
REQ-002 Parameter ADDR_WIDTH, default 32: width of word addresses; sizes/counts are ADDR_WIDTH+1 bits.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 go  in  1  start request; sampled only in IDLE or DONE.
REQ-006 src_addr  in  ADDR_WIDTH  read start address, latched on accepted go.
REQ-007 dst_addr  in  ADDR_WIDTH  write start address, latched on accepted go.
REQ-008 size  in  ADDR_WIDTH+1  words to copy, latched on accepted go.
REQ-009 busy  out  1  high from the cycle after an accepted go until the cycle DONE is entered.
REQ-010 done  out  1  level; high in DONE, cleared by the next accepted go.
REQ-011 rd_go, wr_go  out  1 each  single-cycle start pulses to the memory side.
REQ-012 rd_addr, wr_addr  out  ADDR_WIDTH each  registered copies of src_addr and dst_addr.
REQ-013 rd_size, wr_size  out  ADDR_WIDTH+1 each  registered copy of size.
REQ-014 rd_en  out  1  pops one word from the read side.
REQ-015 rd_data  in  DATA_WIDTH  read word, valid whenever empty=0 (first-word fall-through).
REQ-016 empty  in  1  no read word available.
REQ-017 rd_done  in  1  read engine finished; may be a pulse or a level.
REQ-018 wr_en  out  1  pushes one word to the write side.
REQ-019 wr_data  out  DATA_WIDTH  word being written.
REQ-020 full  in  1  write side cannot accept a word.
REQ-021 wr_done  in  1  write engine finished; may be a pulse or a level.

Function
REQ-022 FSM states: IDLE, START, COPY, WAIT_DONE, DONE.
REQ-023 IDLE/DONE with go=1 and size!=0 -> START; latch addresses and size; clear done, word count, and sticky done flags.
REQ-024 IDLE/DONE with go=1 and size=0 -> DONE next cycle, with done=1 and no rd_go/wr_go pulse.
REQ-025 START lasts exactly one cycle with rd_go=wr_go=1; rd_addr, rd_size, wr_addr and wr_size are already valid in that cycle; next state COPY.
REQ-026 rd_go and wr_go shall be 0 in every state except START.
REQ-027 In COPY, rd_en = wr_en = (empty=0) and (full=0) and (count<size); wr_data = rd_data combinationally.
REQ-028 count (ADDR_WIDTH+1 bits) increments by 1 on every cycle with rd_en=1; rd_en is never asserted once count=size.
REQ-029 COPY -> WAIT_DONE in the cycle after count reaches size.
REQ-030 Sticky flags rd_done_seen and wr_done_seen are set by rd_done and wr_done in any state from START onward, including pulses that arrive before WAIT_DONE.
REQ-031 WAIT_DONE -> DONE when both flags are set, or when both inputs are high in the same cycle; then done=1 and busy=0.
REQ-032 go received in START, COPY or WAIT_DONE shall be ignored, with no change to latched values.
REQ-033 Outside COPY, rd_en and wr_en shall be 0.
REQ-034 In DONE, rd_addr, wr_addr, rd_size and wr_size hold their values until the next accepted go.
REQ-035 A simultaneous empty=0 and full=1 shall produce no pop and no push, and no word shall be lost or duplicated.

Reset
REQ-036 rst=1 forces IDLE from any state, including mid-COPY, within one clock.
REQ-037 Reset values: busy=0, done=0, rd_go=0, wr_go=0, rd_en=0, wr_en=0, count=0, sticky flags=0, and rd_addr, wr_addr, rd_size, wr_size all 0.
REQ-038 go sampled in the same cycle as rst=1 shall be ignored.

Verification
REQ-039 size=4, src=0x10, dst=0x80, empty=0, full=0 -> rd_go/wr_go pulse 1 cycle after go; 4 consecutive rd_en/wr_en cycles with wr_data=rd_data; rd_done and wr_done then both pulsed -> done=1 the next cycle.
REQ-040 size=0 -> done=1 one cycle after go, with no rd_go, wr_go, rd_en or wr_en activity.
REQ-041 size=8 with random empty/full toggling, including cycles where both block -> exactly 8 pushes, written in read order, and no rd_en while empty=1 or full=1.
REQ-042 rd_done pulsed during COPY and wr_done pulsed 5 cycles after count reaches size -> done=1 one cycle after the wr_done pulse.
REQ-043 rst asserted on the 3rd COPY transfer -> all outputs at reset values next cycle; a new go with size=2 then completes normally with exactly 2 transfers.
REQ-044 go pulsed during COPY with different addresses -> ignored; rd_addr and wr_addr unchanged and the transfer count equals the original size.

Source files
------------

// File: rtl/dma_copy_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dma_copy_ctrl
// Description : Word-copy controller that starts a read and a write engine,
//               then moves words from the read FIFO into the write FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_copy_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [ADDR_WIDTH:0]   size,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_go,
  output logic                  wr_go,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH:0]   rd_size,
  output logic [ADDR_WIDTH:0]   wr_size,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  empty,
  input  logic                  rd_done,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  full,
  input  logic                  wr_done
);

  localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_COPY      = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_WIDTH:0] count;
  logic                rd_done_seen;
  logic                wr_done_seen;
  logic                accept;
  logic                xfer;

  assign wr_data = rd_data;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    xfer      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    rd_go     = 1'b0;
    wr_go     = 1'b0;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        done   = (state == S_DONE);
        accept = go;
        if (go) begin
          state_nxt = (size == '0) ? S_DONE : S_START;
        end
      end
      S_START: begin
        busy      = 1'b1;
        rd_go     = 1'b1;
        wr_go     = 1'b1;
        state_nxt = S_COPY;
      end
      S_COPY: begin
        busy  = 1'b1;
        xfer  = !empty && !full && (count < rd_size);
        rd_en = xfer;
        wr_en = xfer;
        // Leave as soon as the last word has moved so WAIT_DONE starts with count == size.
        if ((count == rd_size) || (xfer && ((count + CNT_ONE) == rd_size))) begin
          state_nxt = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        busy = 1'b1;
        if ((rd_done_seen || rd_done) && (wr_done_seen || wr_done)) begin
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      count        <= '0;
      rd_done_seen <= 1'b0;
      wr_done_seen <= 1'b0;
      rd_addr      <= '0;
      wr_addr      <= '0;
      rd_size      <= '0;
      wr_size      <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rd_addr      <= src_addr;
        wr_addr      <= dst_addr;
        rd_size      <= size;
        wr_size      <= size;
        count        <= '0;
        rd_done_seen <= 1'b0;
        wr_done_seen <= 1'b0;
      end else begin
        if (xfer) begin
          count <= count + CNT_ONE;
        end
        // Engines may finish early, so completions are remembered from START on.
        if (busy && rd_done) begin
          rd_done_seen <= 1'b1;
        end
        if (busy && wr_done) begin
          wr_done_seen <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dma_copy_ctrl.sv
`default_nettype none
// Bench for dma_copy_ctrl: table of copy jobs plus hand-written reset/corner sequences,
// with a scoreboard queue of expected words checked at every push.
module tb_dma_copy_ctrl;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst, go, empty, full, rd_done, wr_done;
  logic [AW-1:0] src_addr, dst_addr;
  logic [AW:0]   size;
  logic          busy, done, rd_go, wr_go, rd_en, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [AW:0]   rd_size, wr_size;
  logic [DW-1:0] rd_data, wr_data;

  always #5 clk = ~clk;

  dma_copy_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .go(go), .src_addr(src_addr), .dst_addr(dst_addr), .size(size),
    .busy(busy), .done(done), .rd_go(rd_go), .wr_go(wr_go),
    .rd_addr(rd_addr), .wr_addr(wr_addr), .rd_size(rd_size), .wr_size(wr_size),
    .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .rd_done(rd_done),
    .wr_en(wr_en), .wr_data(wr_data), .full(full), .wr_done(wr_done)
  );

  typedef struct {
    int          sz;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    int          pe;         // percent chance of empty per cycle
    int          pf;         // percent chance of full per cycle
    int          exp_cycles; // copy cycles expected, -1 when stalls make it random
    int          rdd_at;     // copy cycle on which rd_done pulses, -1 = pulse with wr_done
    int          go_at;      // copy cycle on which a stray go is driven, -1 = none
    int          wrd_delay;  // idle cycles after the last word before wr_done
  } vec_t;

  vec_t          tbl[6];
  logic [DW-1:0] rd_q[$];
  logic [DW-1:0] exp_q[$];
  int            n_pass  = 0;
  int            n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic present(input int pe, input int pf);
    empty   = (int'($urandom_range(99)) < pe);
    full    = (int'($urandom_range(99)) < pf);
    rd_data = (rd_q.size() != 0) ? rd_q[0] : 32'hDEAD_BEEF;
  endtask

  // Called #1 after inputs settle; consumes one scoreboard entry per push.
  task automatic observe(output bit popped);
    popped = 1'b0;
    if (empty || full) chk("blocked_no_pop", rd_en, 1'b0);
    if (rd_en || wr_en) begin
      chk("en_pair", wr_en, rd_en);
      if (exp_q.size() == 0) chk("extra_push", {rd_en, wr_en}, 2'b00);
      else chk("wr_data", wr_data, exp_q.pop_front());
      if (rd_q.size() != 0) rd_q.delete(0);
      popped = 1'b1;
    end
  endtask

  task automatic do_copy(input vec_t v, output int xfers);
    logic [DW-1:0] w;
    bit p;
    int cyc;
    rd_q.delete();
    exp_q.delete();
    @(negedge clk);
    go = 1'b1; src_addr = v.src; dst_addr = v.dst; size = (AW+1)'(v.sz);
    empty = 1'b1; full = 1'b0;
    for (int i = 0; i < v.sz; i++) begin
      w = $urandom;
      rd_q.push_back(w);
      exp_q.push_back(w);
    end
    #1 chk("go_cycle_rd_go", rd_go, 1'b0);
    @(negedge clk);
    go = 1'b0; src_addr = $urandom; dst_addr = $urandom; size = '0;
    empty = 1'b0; full = 1'b0; rd_data = rd_q[0];
    #1;
    chk("start_pulses", {rd_go, wr_go, busy, done, rd_en}, 5'b11100);
    chk("start_rd_addr", rd_addr, v.src);
    chk("start_wr_addr", wr_addr, v.dst);
    chk("start_rd_size", rd_size, v.sz);
    chk("start_wr_size", wr_size, v.sz);
    xfers = 0;
    cyc   = 0;
    while (xfers < v.sz) begin
      if (cyc >= 500) begin
        chk("copy_timeout", xfers, v.sz);
        break;
      end
      @(negedge clk);
      go = 1'b0; rd_done = 1'b0;
      if (cyc == v.go_at) begin
        go = 1'b1; src_addr = ~v.src; dst_addr = ~v.dst; size = (AW+1)'(v.sz + 3);
      end
      if (cyc == v.rdd_at) rd_done = 1'b1;
      present(v.pe, v.pf);
      #1;
      chk("copy_no_go_pulse", {rd_go, wr_go}, 2'b00);
      observe(p);
      if (p) xfers++;
      cyc++;
    end
    if (v.exp_cycles >= 0) chk("copy_cycles", cyc, v.exp_cycles);
  endtask

  task automatic finish_copy(input vec_t v);
    bit p;
    for (int k = 0; k < v.wrd_delay; k++) begin
      @(negedge clk);
      go = 1'b0; rd_done = 1'b0; empty = 1'b0; full = 1'b0; rd_data = 32'hDEAD_BEEF;
      #1;
      observe(p);
      chk("wait_busy", {busy, done}, 2'b10);
    end
    @(negedge clk);
    go = 1'b0; wr_done = 1'b1; rd_done = (v.rdd_at < 0);
    #1 chk("pre_done", done, 1'b0);
    @(negedge clk);
    wr_done = 1'b0; rd_done = 1'b0;
    #1;
    chk("done_state", {busy, done, rd_en, rd_go}, 4'b0100);
    chk("done_rd_addr", rd_addr, v.src);
    chk("done_wr_addr", wr_addr, v.dst);
    chk("done_rd_size", rd_size, v.sz);
    chk("done_wr_size", wr_size, v.sz);
    chk("sb_drained", exp_q.size(), 0);
  endtask

  initial begin
    int   xf;
    bit   p;
    vec_t v2;
    tbl[0] = '{4,  32'h10,        32'h80,   0,  0,  4, -1, -1, 1};
    tbl[1] = '{8,  32'h1000,      32'h2000, 40, 40, -1, -1, -1, 2};
    tbl[2] = '{6,  32'h20,        32'h30,   0,  0,  6,  2, -1, 5};
    tbl[3] = '{6,  32'hA0,        32'hB0,   0,  0,  6, -1,  2, 1};
    tbl[4] = '{16, 32'hFFFF_FFF0, 32'h0,    30, 50, -1, -1, -1, 3};
    tbl[5] = '{1,  32'h5,         32'h6,    60, 0, -1,  0, -1, 1};
    v2     = '{2,  32'h300,       32'h400,  0,  0,  2, -1, -1, 1};

    rst = 1'b1; go = 1'b0; empty = 1'b1; full = 1'b0; rd_done = 1'b0; wr_done = 1'b0;
    src_addr = '0; dst_addr = '0; size = '0; rd_data = '0;
    repeat (2) @(negedge clk);
    // go during reset must be dropped
    go = 1'b1; size = 33'd5; src_addr = 32'h77; empty = 1'b0;
    #1;
    chk("rst_ctrl", {busy, done, rd_go, wr_go, rd_en, wr_en}, 6'b0);
    chk("rst_addr", {rd_addr, wr_addr}, 64'h0);
    chk("rst_size", {rd_size[31:0], wr_size[31:0]}, 64'h0);
    @(negedge clk);
    rst = 1'b0; go = 1'b0;
    #1 chk("go_in_rst_ignored", {busy, rd_go, rd_addr[7:0]}, 10'h0);

    // size 0 completes immediately without engine activity
    @(negedge clk);
    go = 1'b1; size = '0; src_addr = 32'h44;
    #1 chk("zero_pre_done", done, 1'b0);
    @(negedge clk);
    go = 1'b0;
    #1 chk("zero_done", {done, busy, rd_go, wr_go}, 4'b1000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 chk("zero_quiet", {done, rd_go, wr_go, rd_en, wr_en}, 5'b10000);
    end

    foreach (tbl[i]) begin
      do_copy(tbl[i], xf);
      finish_copy(tbl[i]);
    end

    // reset while the third word is being moved
    rd_q.delete();
    exp_q.delete();
    for (int i = 0; i < 6; i++) rd_q.push_back($urandom);
    exp_q = rd_q;
    @(negedge clk);
    go = 1'b1; src_addr = 32'h40; dst_addr = 32'h50; size = 33'd6; empty = 1'b1;
    @(negedge clk);
    go = 1'b0; present(0, 0);
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      present(0, 0);
      #1 observe(p);
    end
    @(negedge clk);
    present(0, 0); rst = 1'b1;
    #1 chk("xfer3_active", rd_en, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midcopy_rst_ctrl", {busy, done, rd_go, wr_go, rd_en, wr_en}, 6'b0);
    chk("midcopy_rst_addr", {rd_addr, wr_addr}, 64'h0);
    chk("midcopy_rst_size", {rd_size[31:0], wr_size[31:0]}, 64'h0);
    do_copy(v2, xf);
    finish_copy(v2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
